// File: rtl/uart_pkg.sv
// Shared types, divider calculation and baud-error limit for the UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    localparam int BAUD_ERR_PCT = 2;

    // Rounded clock divider giving one tick per oversample period.
    function automatic int calc_div(input longint clk_hz, input longint baud, input longint oversample);
        longint den;
        den = baud * oversample;
        return int'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & valid;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign do_push = push & (~full | do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: majority-vote bit decisions, parity/framing
// checks, break detection and an FWFT output FIFO with sticky overflow.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          break_o,
    output logic                          overflow_o,
    input  logic                          clr_err_i
);

    localparam int      DIV      = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int      CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int      SW       = $clog2(OVERSAMPLE);
    localparam int      BCW      = $clog2(DATA_BITS + 1);
    localparam parity_e PAR_MODE = parity_e'(PARITY);
    localparam longint  ACT_HZ   = longint'(DIV) * OVERSAMPLE * BAUD;
    localparam longint  DIFF_HZ  = (ACT_HZ > CLK_HZ) ? ACT_HZ - CLK_HZ : CLK_HZ - ACT_HZ;

    generate
        if (DIV < 1 || DIFF_HZ * 100 > longint'(BAUD_ERR_PCT) * CLK_HZ
            || OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0
            || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2
            || STOP_BITS < 1 || STOP_BITS > 2
            || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
            $error("uart_rx: unsupported parameter set or baud error above limit");
        end
    endgenerate

    rx_state_e            state, state_next;
    logic                 sync1, sync2, prev;
    logic [CW-1:0]        tcnt;
    logic [SW-1:0]        s;
    logic [BCW-1:0]       bit_cnt;
    logic                 v_a, v_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, stop_bad;
    logic                 parity_err, frame_err, brk, overflow;

    logic tick, fall, at_s1, at_s2, decide, bit_end, maj, exp_par;
    logic frame_done, stop_low, push, pop, drop, fifo_full;

    assign tick    = (tcnt == CW'(DIV - 1));
    assign fall    = prev & ~sync2;
    assign at_s1   = tick && (s == SW'(OVERSAMPLE / 2 - 1));
    assign at_s2   = tick && (s == SW'(OVERSAMPLE / 2));
    assign decide  = tick && (s == SW'(OVERSAMPLE / 2 + 1));
    assign bit_end = tick && (s == SW'(OVERSAMPLE - 1));
    assign maj     = (v_a & v_b) | (v_a & sync2) | (v_b & sync2);
    assign exp_par = (PAR_MODE == ODD) ? ~^shreg : ^shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        unique case (state)
            S_IDLE:   if (fall) state_next = S_START;
            S_START: begin
                if (decide && maj) state_next = S_IDLE;
                else if (bit_end)  state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_cnt == BCW'(DATA_BITS - 1))
                    state_next = (PAR_MODE != NONE) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_end) state_next = S_STOP;
            S_STOP: begin
                // Leave mid-bit so the next start edge is never missed.
                if (decide && bit_cnt == BCW'(STOP_BITS - 1)) begin
                    state_next = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    assign stop_low = stop_bad | ~maj;
    assign push     = frame_done & ~stop_low & ~par_bad;
    assign pop      = rx_valid_o & rx_ready_i;
    assign drop     = push & fifo_full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            prev       <= 1'b1;
            tcnt       <= '0;
            s          <= '0;
            bit_cnt    <= '0;
            v_a        <= 1'b1;
            v_b        <= 1'b1;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            brk        <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
            prev  <= sync2;

            if ((state == S_IDLE && fall) || tick) tcnt <= '0;
            else                                   tcnt <= tcnt + 1'b1;

            if (state == S_IDLE) s <= '0;
            else if (tick)       s <= (s == SW'(OVERSAMPLE - 1)) ? '0 : s + 1'b1;

            if (state_next != state) bit_cnt <= '0;
            else if (bit_end)        bit_cnt <= bit_cnt + 1'b1;

            if (at_s1) v_a <= sync2;
            if (at_s2) v_b <= sync2;

            if (state == S_DATA && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};

            if (state == S_IDLE)                    par_bad <= 1'b0;
            else if (state == S_PARITY && decide)   par_bad <= (maj != exp_par);

            if (state == S_IDLE)                        stop_bad <= 1'b0;
            else if (state == S_STOP && decide && !maj) stop_bad <= 1'b1;

            parity_err <= frame_done & par_bad;
            frame_err  <= frame_done & stop_low;
            brk        <= frame_done & stop_low & (shreg == '0);

            if (drop)           overflow <= 1'b1;
            else if (clr_err_i) overflow <= 1'b0;
        end
    end

    assign parity_err_o = parity_err;
    assign frame_err_o  = frame_err;
    assign break_o      = brk;
    assign overflow_o   = overflow;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .head      (rx_data_o),
        .valid     (rx_valid_o),
        .full      (fifo_full),
        .count     (fifo_count_o)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized checks of uart_rx: an 8N1 instance (depth 4) and an 8E1 instance (depth 16).
module tb_uart_rx;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rx_n = 1'b1, ready_n = 1'b0, clr_n = 1'b0;
    logic [7:0] data_n;
    logic       valid_n, pe_n, fe_n, br_n, ov_n;
    logic [2:0] count_n;

    logic       rx_e = 1'b1, ready_e = 1'b0, clr_e = 1'b0;
    logic [7:0] data_e;
    logic       valid_e, pe_e, fe_e, br_e, ov_e;
    logic [4:0] count_e;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
              .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
        .clk(clk), .rst(rst), .rx_i(rx_n), .rx_data_o(data_n), .rx_valid_o(valid_n),
        .rx_ready_i(ready_n), .fifo_count_o(count_n), .parity_err_o(pe_n),
        .frame_err_o(fe_n), .break_o(br_n), .overflow_o(ov_n), .clr_err_i(clr_n));

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
              .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_e (
        .clk(clk), .rst(rst), .rx_i(rx_e), .rx_data_o(data_e), .rx_valid_o(valid_e),
        .rx_ready_i(ready_e), .fifo_count_o(count_e), .parity_err_o(pe_e),
        .frame_err_o(fe_e), .break_o(br_e), .overflow_o(ov_e), .clr_err_i(clr_e));

    int total = 0;
    int bad   = 0;

    // Pulse-cycle counters; a pulse wider than one cycle shows up as an extra count.
    int pe_cnt_n = 0, fe_cnt_n = 0, br_cnt_n = 0, both_n = 0;
    int pe_cnt_e = 0, fe_cnt_e = 0, br_cnt_e = 0;

    always @(negedge clk) begin
        if (pe_n) pe_cnt_n++;
        if (fe_n) fe_cnt_n++;
        if (br_n) br_cnt_n++;
        if (fe_n && br_n) both_n++;
        if (pe_e) pe_cnt_e++;
        if (fe_e) fe_cnt_e++;
        if (br_e) br_cnt_e++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input int cycles);
        if (sel) rx_e = v;
        else     rx_n = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit par_en,
                        input logic par, input logic stop);
        drive(sel, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLKS);
        if (par_en) drive(sel, par, BIT_CLKS);
        drive(sel, stop, BIT_CLKS);
        drive(sel, 1'b1, 6);
    endtask

    task automatic pop(input bit sel);
        if (sel) ready_e = 1'b1;
        else     ready_n = 1'b1;
        @(negedge clk);
        ready_e = 1'b0;
        ready_n = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       stop_v, par_v, pok, push_exp;
        int         fe0, br0, pe0, efe0;
        logic [7:0] msg;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid_n", valid_n, 0);
        check("rst_count_n", count_n, 0);
        check("rst_data_n",  data_n, 0);
        check("rst_ov_n",    ov_n, 0);
        check("rst_valid_e", valid_e, 0);
        check("rst_count_e", count_e, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 single word
        send(0, 8'h55, 0, 0, 1);
        check("n55_valid", valid_n, 1);
        check("n55_data",  data_n, 8'h55);
        check("n55_count", count_n, 1);
        check("n55_fe",    fe_cnt_n, 0);
        check("n55_br",    br_cnt_n, 0);
        check("n55_pe",    pe_cnt_n, 0);
        pop(0);
        check("n55_pop_count", count_n, 0);
        check("n55_pop_valid", valid_n, 0);

        // Even parity: 0xA3 has four ones, so the correct parity bit is 0
        send(1, 8'hA3, 1, 1, 1);
        check("par_bad_pulse", pe_cnt_e, 1);
        check("par_bad_valid", valid_e, 0);
        send(1, 8'hA3, 1, 0, 1);
        check("par_ok_valid", valid_e, 1);
        check("par_ok_data",  data_e, 8'hA3);
        check("par_ok_pulse", pe_cnt_e, 1);
        pop(1);

        // Framing and break
        send(0, 8'h00, 0, 0, 0);
        check("brk_fe",    fe_cnt_n, 1);
        check("brk_br",    br_cnt_n, 1);
        check("brk_both",  both_n, 1);
        check("brk_valid", valid_n, 0);
        send(0, 8'h41, 0, 0, 0);
        check("fe41_fe",    fe_cnt_n, 2);
        check("fe41_br",    br_cnt_n, 1);
        check("fe41_valid", valid_n, 0);

        // Glitch rejection
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 40);
        check("glitch_valid", valid_n, 0);
        check("glitch_fe",    fe_cnt_n, 2);
        check("glitch_br",    br_cnt_n, 1);
        send(0, 8'h5A, 0, 0, 1);
        check("post_glitch_data", data_n, 8'h5A);
        pop(0);

        // Overflow with depth 4
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 0, 1);
        check("ovf_count", count_n, 4);
        check("ovf_flag",  ov_n, 1);
        repeat (5) @(negedge clk);
        check("ovf_hold_data", data_n, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            msg = 8'(i);
            check("ovf_read", data_n, msg);
            pop(0);
        end
        check("ovf_empty",  valid_n, 0);
        check("ovf_sticky", ov_n, 1);
        clr_n = 1'b1;
        @(negedge clk);
        clr_n = 1'b0;
        check("ovf_clr", ov_n, 0);

        // Reset mid-frame
        send(0, 8'h7E, 0, 0, 1);
        check("pre_rst_count", count_n, 1);
        drive(0, 1'b0, BIT_CLKS);
        d = 8'h3C;
        for (int i = 0; i < 3; i++) drive(0, d[i], BIT_CLKS);
        drive(0, d[3], 5);
        rst  = 1'b1;
        rx_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", valid_n, 0);
        check("mid_rst_count", count_n, 0);
        check("mid_rst_data",  data_n, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fe0 = fe_cnt_n;
        repeat (20) @(negedge clk);
        send(0, 8'hC3, 0, 0, 1);
        check("post_rst_count", count_n, 1);
        check("post_rst_data",  data_n, 8'hC3);
        check("post_rst_fe",    fe_cnt_n, fe0);
        pop(0);
        check("post_rst_empty", count_n, 0);

        // Randomized 8N1 frames against the frame-rule model
        for (int k = 0; k < 16; k++) begin
            d      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            fe0 = fe_cnt_n;
            br0 = br_cnt_n;
            send(0, d, 0, 0, stop_v);
            check("rnd_n_valid", valid_n, stop_v);
            if (stop_v) begin
                check("rnd_n_data", data_n, d);
                pop(0);
            end
            check("rnd_n_fe", fe_cnt_n - fe0, !stop_v);
            check("rnd_n_br", br_cnt_n - br0, (!stop_v && d == 8'h00));
        end

        // Randomized 8E1 frames with random parity and stop errors
        for (int k = 0; k < 16; k++) begin
            d      = 8'($urandom);
            pok    = ($urandom_range(0, 2) != 0);
            stop_v = ($urandom_range(0, 4) != 0);
            par_v  = pok ? ^d : ~^d;
            push_exp = pok && stop_v;
            pe0  = pe_cnt_e;
            efe0 = fe_cnt_e;
            send(1, d, 1, par_v, stop_v);
            check("rnd_e_valid", valid_e, push_exp);
            if (push_exp) begin
                check("rnd_e_data", data_e, d);
                pop(1);
            end
            check("rnd_e_pe", pe_cnt_e - pe0, !pok);
            check("rnd_e_fe", fe_cnt_e - efe0, !stop_v);
        end
        check("rnd_e_ov", ov_e, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
